uart_echo_buffer: RTL and testbench

Parametrised, buffered successor to the combinational loopback glue between the `Uart` receive and transmit handshakes. It accepts received words into a synchronous FIFO and retransmits them through the `Uart` write handshake. Received words are optionally transformed (ASCII uppercase), held, or discarded, and overflow is reported and counted. It sits between the `Uart` instance and the board top, so bursts arriving faster than the transmitter drains them are no longer lost.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_sync_fifo.sv | 57 +++++
 rtl/uart_echo_buffer.sv | 136 +++++++++++++
 tb/tb_uart_echo_buffer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings for the UART echo buffer: operating modes, RX/TX state machine states, ASCII constants.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package uart_pkg;

    typedef enum logic [1:0] {
        UART_MODE_ECHO    = 2'd0,
        UART_MODE_UPPER   = 2'd1,
        UART_MODE_HOLD    = 2'd2,
        UART_MODE_DISCARD = 2'd3
    } uart_mode_e;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_ACK  = 1'b1
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_REQ  = 2'd1,
        TX_BUSY = 2'd2
    } tx_state_e;

    // Lowercase ASCII range; clearing the case bit maps it onto uppercase.
    localparam logic [7:0] ASCII_LOWER_A  = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z  = 8'h7A;
    localparam int         ASCII_CASE_BIT = 5;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Latency: a pushed word is visible on head one cycle after the push edge.
// Backpressure: push is ignored when full unless a pop happens in the same cycle; pop is ignored when empty.
module uart_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] head,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);
    import uart_pkg::*;

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally at their width; count tracks net push/pop.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
                2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clock_i) begin
        if (do_push) mem[wr_ptr] <= data;
    end

endmodule

// File: rtl/uart_echo_buffer.sv
// Buffered UART loopback: RX handshake pushes into a FIFO, TX handshake pops (optionally uppercased) words.
// Latency: rx_ready sampled at edge k -> ack and count=1 after k; tx_write rises after k+1 when TX is idle.
// Backpressure: words arriving to a full FIFO are still acknowledged but dropped and counted as overflow.
module uart_echo_buffer #(
    parameter int DATA_WIDTH       = 8,
    parameter int DEPTH_LOG2       = 4,
    parameter int DROP_COUNT_WIDTH = 8
) (
    input  logic                        clock_i,
    input  logic                        reset_n_i,
    input  logic [1:0]                  mode_i,
    input  logic                        clear_status_i,
    input  logic [DATA_WIDTH-1:0]       rx_data_i,
    input  logic                        rx_ready_i,
    output logic                        rx_ack_o,
    output logic [DATA_WIDTH-1:0]       tx_data_o,
    output logic                        tx_write_o,
    input  logic                        tx_busy_i,
    output logic [DEPTH_LOG2:0]         count_o,
    output logic                        overflow_o,
    output logic [DROP_COUNT_WIDTH-1:0] drop_count_o
);
    import uart_pkg::*;

    uart_mode_e            mode;
    rx_state_e             rx_state;
    tx_state_e             tx_state;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic [DATA_WIDTH-1:0] head_xf;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  rx_take;
    logic                  keep;
    logic                  push;
    logic                  pop;
    logic                  overflow_evt;

    assign mode    = uart_mode_e'(mode_i);
    assign rx_take = (rx_state == RX_IDLE) && rx_ready_i;
    assign pop     = (tx_state == TX_IDLE) && !fifo_empty && !tx_busy_i && (mode != UART_MODE_HOLD);
    // Discard mode acknowledges words but never stores them, so it cannot overflow.
    assign keep         = rx_take && (mode != UART_MODE_DISCARD);
    assign push         = keep && !(fifo_full && !pop);
    assign overflow_evt = keep && fifo_full && !pop;

    uart_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .push      (push),
        .pop       (pop),
        .data      (rx_data_i),
        .head      (fifo_head),
        .count     (count_o),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Uppercase transform applied to the FIFO head at pop time.
    always_comb begin
        head_xf = fifo_head;
        if (mode == UART_MODE_UPPER &&
            fifo_head >= DATA_WIDTH'(ASCII_LOWER_A) &&
            fifo_head <= DATA_WIDTH'(ASCII_LOWER_Z)) begin
            head_xf[ASCII_CASE_BIT] = 1'b0;
        end
    end

    // RX four-phase handshake: ack a pending word, hold ack until ready falls.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rx_state <= RX_IDLE;
            rx_ack_o <= 1'b0;
        end else begin
            case (rx_state)
                RX_IDLE: if (rx_ready_i) begin
                    rx_state <= RX_ACK;
                    rx_ack_o <= 1'b1;
                end
                RX_ACK: if (!rx_ready_i) begin
                    rx_state <= RX_IDLE;
                    rx_ack_o <= 1'b0;
                end
                default: begin
                    rx_state <= RX_IDLE;
                    rx_ack_o <= 1'b0;
                end
            endcase
        end
    end

    // TX handshake: pop into a stable data register, request until busy seen, wait for busy to clear.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tx_state   <= TX_IDLE;
            tx_write_o <= 1'b0;
            tx_data_o  <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: if (pop) begin
                    tx_data_o  <= head_xf;
                    tx_write_o <= 1'b1;
                    tx_state   <= TX_REQ;
                end
                TX_REQ: if (tx_busy_i) begin
                    tx_write_o <= 1'b0;
                    tx_state   <= TX_BUSY;
                end
                TX_BUSY: if (!tx_busy_i) begin
                    tx_state <= TX_IDLE;
                end
                default: begin
                    tx_state   <= TX_IDLE;
                    tx_write_o <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter; a clear pulse beats a coincident overflow.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            overflow_o   <= 1'b0;
            drop_count_o <= '0;
        end else if (clear_status_i) begin
            overflow_o   <= 1'b0;
            drop_count_o <= '0;
        end else if (overflow_evt) begin
            overflow_o <= 1'b1;
            if (drop_count_o != '1) drop_count_o <= drop_count_o + DROP_COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Directed self-checking bench for uart_echo_buffer with a 4-deep FIFO.
// Latency: drives inputs and samples outputs 1 ns after each rising edge.
// Backpressure: models the Uart transmitter busy handshake by hand.
module tb_uart_echo_buffer;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic       clr;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_ack;
    logic [7:0] tx_data;
    logic       tx_write;
    logic       tx_busy;
    logic [2:0] count;
    logic       overflow;
    logic [7:0] drop_count;

    int checks = 0;
    int errors = 0;

    uart_echo_buffer #(
        .DATA_WIDTH       (8),
        .DEPTH_LOG2       (2),
        .DROP_COUNT_WIDTH (8)
    ) dut (
        .clock_i        (clk),
        .reset_n_i      (rst_n),
        .mode_i         (mode),
        .clear_status_i (clr),
        .rx_data_i      (rx_data),
        .rx_ready_i     (rx_ready),
        .rx_ack_o       (rx_ack),
        .tx_data_o      (tx_data),
        .tx_write_o     (tx_write),
        .tx_busy_i      (tx_busy),
        .count_o        (count),
        .overflow_o     (overflow),
        .drop_count_o   (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full four-phase RX handshake for one byte, bounded in cycles.
    task automatic send_byte(input logic [7:0] b);
        logic seen;
        seen     = 1'b0;
        rx_data  = b;
        rx_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rx_ack) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("rx_ack_timeout", 32'(seen), 32'd1);
        rx_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!rx_ack) break;
        end
    endtask

    // Wait for a TX request, compare the word, then complete the busy handshake.
    task automatic expect_tx(input logic [7:0] exp, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (tx_write) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk({tag, "_write"}, 32'(seen), 32'd1);
        chk({tag, "_data"}, 32'(tx_data), 32'(exp));
        tx_busy = 1'b1;
        step();
        chk({tag, "_write_drop"}, 32'(tx_write), 32'd0);
        tx_busy = 1'b0;
        step();
    endtask

    initial begin
        rst_n    = 1'b0;
        mode     = 2'd0;
        clr      = 1'b0;
        rx_data  = 8'h00;
        rx_ready = 1'b0;
        tx_busy  = 1'b0;
        #12;
        chk("rst_rx_ack", 32'(rx_ack), 32'd0);
        chk("rst_tx_write", 32'(tx_write), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        rst_n = 1'b1;
        step();

        // Single byte echo with exact cycle latency.
        rx_data  = 8'h41;
        rx_ready = 1'b1;
        step();
        chk("e1_ack", 32'(rx_ack), 32'd1);
        chk("e1_count1", 32'(count), 32'd1);
        chk("e1_write_early", 32'(tx_write), 32'd0);
        rx_ready = 1'b0;
        step();
        chk("e1_write", 32'(tx_write), 32'd1);
        chk("e1_data", 32'(tx_data), 32'h41);
        chk("e1_count0", 32'(count), 32'd0);
        step();
        chk("e1_write_held", 32'(tx_write), 32'd1);
        tx_busy = 1'b1;
        step();
        chk("e1_write_drop", 32'(tx_write), 32'd0);
        tx_busy = 1'b0;
        step();

        // Uppercase mode, bytes buffered while the transmitter reports busy.
        mode    = 2'd1;
        tx_busy = 1'b1;
        send_byte(8'h61);
        send_byte(8'h7A);
        send_byte(8'h5B);
        send_byte(8'hE1);
        chk("up_count", 32'(count), 32'd4);
        tx_busy = 1'b0;
        expect_tx(8'h41, "up0");
        expect_tx(8'h5A, "up1");
        expect_tx(8'h5B, "up2");
        expect_tx(8'hE1, "up3");

        // Hold mode: six arrivals into four slots.
        mode = 2'd2;
        for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i));
        chk("hold_count", 32'(count), 32'd4);
        chk("hold_overflow", 32'(overflow), 32'd1);
        chk("hold_drop", 32'(drop_count), 32'd2);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("hold_clr_ovf", 32'(overflow), 32'd0);
        chk("hold_clr_drop", 32'(drop_count), 32'd0);

        // Full FIFO: busy falls in the same cycle a new byte arrives.
        mode    = 2'd0;
        tx_busy = 1'b1;
        step();
        chk("co_count_pre", 32'(count), 32'd4);
        tx_busy  = 1'b0;
        rx_data  = 8'h16;
        rx_ready = 1'b1;
        step();
        chk("co_count", 32'(count), 32'd4);
        chk("co_overflow", 32'(overflow), 32'd0);
        chk("co_drop", 32'(drop_count), 32'd0);
        chk("co_ack", 32'(rx_ack), 32'd1);
        rx_ready = 1'b0;
        expect_tx(8'h10, "dr0");
        expect_tx(8'h11, "dr1");
        expect_tx(8'h12, "dr2");
        expect_tx(8'h13, "dr3");
        expect_tx(8'h16, "dr4");
        chk("dr_count", 32'(count), 32'd0);

        // Discard mode acknowledges without storing or transmitting.
        mode = 2'd3;
        send_byte(8'h33);
        step();
        chk("disc_count", 32'(count), 32'd0);
        chk("disc_write", 32'(tx_write), 32'd0);
        chk("disc_overflow", 32'(overflow), 32'd0);

        // Drop counter saturation.
        mode = 2'd2;
        for (int i = 0; i < 4; i++) send_byte(8'h20 + 8'(i));
        for (int i = 0; i < 300; i++) send_byte(8'hAA);
        chk("sat_count", 32'(count), 32'd4);
        chk("sat_overflow", 32'(overflow), 32'd1);
        chk("sat_drop", 32'(drop_count), 32'hFF);

        // Clear coincides with an overflow arrival: clear wins.
        clr      = 1'b1;
        rx_data  = 8'hBB;
        rx_ready = 1'b1;
        step();
        clr = 1'b0;
        chk("cw_overflow", 32'(overflow), 32'd0);
        chk("cw_drop", 32'(drop_count), 32'd0);
        chk("cw_count", 32'(count), 32'd4);
        rx_ready = 1'b0;
        step();
        send_byte(8'hCC);
        chk("post_clr_drop", 32'(drop_count), 32'd1);
        chk("post_clr_ovf", 32'(overflow), 32'd1);

        // Reset while the TX machine is requesting.
        mode = 2'd0;
        step();
        chk("rq_write", 32'(tx_write), 32'd1);
        chk("rq_data", 32'(tx_data), 32'h20);
        chk("rq_count", 32'(count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_write", 32'(tx_write), 32'd0);
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_data", 32'(tx_data), 32'd0);
        chk("ar_overflow", 32'(overflow), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("ar_idle_write", 32'(tx_write), 32'd0);
        send_byte(8'h55);
        expect_tx(8'h55, "ar_echo");
        chk("ar_final_count", 32'(count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
